// File: rtl/test_pattern_gen_if.sv
// Video timing strobes into the pattern generator and the registered pixel bus out of it.
// The master side is the timing source / pixel sink, the slave side is the generator.
interface test_pattern_gen_if #(
  parameter int PIX_SZ = 8
);
  logic              i_blank;
  logic              i_frame_start;
  logic [PIX_SZ-1:0] o_r;
  logic [PIX_SZ-1:0] o_g;
  logic [PIX_SZ-1:0] o_b;
  logic              o_de;

  modport master (
    output i_blank, i_frame_start,
    input  o_r, o_g, o_b, o_de
  );

  modport slave (
    input  i_blank, i_frame_start,
    output o_r, o_g, o_b, o_de
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Video test pattern generator: colour bars (optionally scrolling), gradient, checkerboard
// or solid colour, with one cycle of latency from the timing strobes to the pixel bus.
module test_pattern_gen #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int PIX_SZ   = 8,
  parameter int NUM_BARS = 8,
  parameter int CHK_LOG2 = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_mode,
  input  logic                i_scroll_en,
  input  logic [3*PIX_SZ-1:0] i_solid_rgb,
  test_pattern_gen_if.slave   vid
);

  localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BAR_W = H_RES / NUM_BARS;

  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] s;
  logic [1:0]    mode_q;

  logic [XW:0]       xs_sum;
  logic [XW-1:0]     xs;
  logic [2:0]        bar_id;
  logic              chk;
  logic [PIX_SZ-1:0] pix_r;
  logic [PIX_SZ-1:0] pix_g;
  logic [PIX_SZ-1:0] pix_b;

  // o_de doubles as "previous cycle was active", which marks the active-to-blank edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      x      <= '0;
      y      <= '0;
      s      <= '0;
      mode_q <= '0;
    end else begin
      if (!vid.i_blank) begin
        if (x != X_MAX) begin
          x <= x + 1'b1;
        end
      end else if (vid.o_de) begin
        x <= '0;
      end

      if (vid.i_frame_start) begin
        y <= '0;
      end else if (vid.i_blank && vid.o_de && (y != Y_MAX)) begin
        y <= y + 1'b1;
      end

      if (vid.i_frame_start) begin
        mode_q <= i_mode;
        if (i_scroll_en) begin
          s <= (s == X_MAX) ? '0 : s + 1'b1;
        end else begin
          s <= '0;
        end
      end
    end
  end

  // Bar index found by comparing against each boundary, avoiding a divider.
  always_comb begin
    xs_sum = {1'b0, x} + {1'b0, s};
    if (xs_sum >= (XW+1)'(H_RES)) begin
      xs = XW'(xs_sum - (XW+1)'(H_RES));
    end else begin
      xs = xs_sum[XW-1:0];
    end
    bar_id = 3'd0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (xs >= XW'(i * BAR_W)) begin
        bar_id = 3'(i);
      end
    end
  end

  always_comb begin
    chk   = (|(x & (XW'(1) << CHK_LOG2))) ^ (|(y & (YW'(1) << CHK_LOG2)));
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_q)
      2'd0: begin
        pix_r = {PIX_SZ{~bar_id[1]}};
        pix_g = {PIX_SZ{~bar_id[2]}};
        pix_b = {PIX_SZ{~bar_id[0]}};
      end
      2'd1: begin
        pix_r = PIX_SZ'(x);
        pix_g = PIX_SZ'(x);
        pix_b = PIX_SZ'(x);
      end
      2'd2: begin
        pix_r = {PIX_SZ{~chk}};
        pix_g = {PIX_SZ{~chk}};
        pix_b = {PIX_SZ{~chk}};
      end
      default: begin
        pix_r = i_solid_rgb[3*PIX_SZ-1:2*PIX_SZ];
        pix_g = i_solid_rgb[2*PIX_SZ-1:PIX_SZ];
        pix_b = i_solid_rgb[PIX_SZ-1:0];
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vid.o_r  <= '0;
      vid.o_g  <= '0;
      vid.o_b  <= '0;
      vid.o_de <= 1'b0;
    end else if (vid.i_blank) begin
      vid.o_r  <= '0;
      vid.o_g  <= '0;
      vid.o_b  <= '0;
      vid.o_de <= 1'b0;
    end else begin
      vid.o_r  <= pix_r;
      vid.o_g  <= pix_g;
      vid.o_b  <= pix_b;
      vid.o_de <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: stimulus pushes expected pixels computed from an
// integer reference model, a monitor pops and compares one entry per clock.
module tb_test_pattern_gen;

  localparam int H  = 640;
  localparam int V  = 20;
  localparam int P  = 8;
  localparam int NB = 8;
  localparam int CK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        scroll_en;
  logic [23:0] solid;

  test_pattern_gen_if #(.PIX_SZ(P)) vid ();

  test_pattern_gen #(
    .H_RES(H), .V_RES(V), .PIX_SZ(P), .NUM_BARS(NB), .CHK_LOG2(CK)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .i_scroll_en (scroll_en),
    .i_solid_rgb (solid),
    .vid         (vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  logic [24:0] mon_exp;
  bit          mon_en = 1'b0;

  int m_px, m_ln, m_s, m_mode;
  bit m_prev_act;

  int cur_mode   = 0;
  bit cur_scroll = 1'b0;
  bit scramble   = 1'b0;

  // Pixel colour straight from the pattern definitions, in plain integer arithmetic.
  function automatic logic [23:0] ref_pixel(input int x, input int y, input int s,
                                            input int md, input logic [23:0] sol);
    int id;
    case (md)
      0: begin
        id = ((x + s) % H) / (H / NB);
        return {(((id >> 1) & 1) != 0) ? 8'h00 : 8'hFF,
                (((id >> 2) & 1) != 0) ? 8'h00 : 8'hFF,
                ((id & 1) != 0)        ? 8'h00 : 8'hFF};
      end
      1: return {3{8'(x % 256)}};
      2: return ((((x >> CK) ^ (y >> CK)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return sol;
    endcase
  endfunction

  task automatic reset_model();
    m_px = 0; m_ln = 0; m_s = 0; m_mode = 0; m_prev_act = 1'b0;
  endtask

  task automatic check_value(input string name, input logic [24:0] got, input logic [24:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got de=%b rgb=%06h want de=%b rgb=%06h",
               name, $time, got[24], got[23:0], want[24], want[23:0]);
    end
  endtask

  task automatic check_output(input logic [24:0] want);
    check_value("pixel", {vid.o_de, vid.o_r, vid.o_g, vid.o_b}, want);
  endtask

  // One clock of stimulus: drive at the falling edge, record what the next rising edge must produce.
  task automatic apply_stimulus(input bit blank, input bit fs);
    int xe;
    @(negedge clk);
    vid.i_blank       = blank;
    vid.i_frame_start = fs;
    mode      = scramble ? 2'($urandom) : 2'(cur_mode);
    scroll_en = cur_scroll;
    solid     = 24'($urandom);
    xe = (m_px < H - 1) ? m_px : H - 1;
    if (mon_en) begin
      if (blank) exp_q.push_back(25'd0);
      else exp_q.push_back({1'b1, ref_pixel(xe, m_ln, m_s, m_mode, solid)});
    end
    if (!blank) begin
      m_px++;
    end else if (m_prev_act) begin
      m_px = 0;
      if (m_ln < V - 1) m_ln++;
    end
    if (fs) begin
      m_ln   = 0;
      m_mode = int'(mode);
      m_s    = cur_scroll ? (m_s + 1) % H : 0;
    end
    m_prev_act = !blank;
  endtask

  task automatic reset_pulse();
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    #1;
    check_value("async_reset", {vid.o_de, vid.o_r, vid.o_g, vid.o_b}, 25'd0);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    #1;
    check_value("reset_hold", {vid.o_de, vid.o_r, vid.o_g, vid.o_b}, 25'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    mon_en = 1'b1;
  endtask

  task automatic run_line(input int act_len, input int hb, input bit fs_first, input int rst_at);
    for (int i = 0; i < act_len; i++) begin
      apply_stimulus(1'b0, 1'b0);
      if (i == rst_at) begin
        reset_pulse();
        break;
      end
    end
    for (int i = 0; i < hb; i++) apply_stimulus(1'b1, fs_first && (i == 0));
  endtask

  task automatic run_frame(input int md, input bit scr, input int lines, input int act_len,
                           input bit scramble_mid);
    cur_mode   = md;
    cur_scroll = scr;
    scramble   = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    scramble = scramble_mid;
    for (int l = 0; l < lines; l++) run_line(act_len, 6, 1'b0, -1);
    scramble = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && (exp_q.size() > 0)) begin
      mon_exp = exp_q.pop_front();
      check_output(mon_exp);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst               = 1'b0;
    vid.i_blank       = 1'b1;
    vid.i_frame_start = 1'b0;
    mode              = 2'd0;
    scroll_en         = 1'b0;
    solid             = 24'h0;
    reset_model();

    // Active strobes during reset must leave the outputs at zero.
    repeat (3) apply_stimulus(1'b0, 1'b1);
    #1;
    check_value("reset_state", {vid.o_de, vid.o_r, vid.o_g, vid.o_b}, 25'd0);
    vid.i_blank       = 1'b1;
    vid.i_frame_start = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    mon_en = 1'b1;

    // Before any frame start the generator stays on bars whatever i_mode says.
    cur_mode = 2;
    run_line(100, 6, 1'b0, -1);

    run_frame(0, 1'b0, 2, 640, 1'b0);
    repeat (3) run_frame(0, 1'b1, 1, 640, 1'b0);
    run_frame(2, 1'b0, 35, 64, 1'b1);
    run_frame(1, 1'b0, 1, 300, 1'b0);

    // Mode change mid-line only takes effect at the next frame start.
    run_frame(0, 1'b0, 0, 0, 1'b0);
    run_line(320, 0, 1'b0, -1);
    cur_mode = 3;
    run_line(320, 6, 1'b0, -1);
    run_frame(3, 1'b0, 2, 640, 1'b0);

    run_frame(1, 1'b0, 2, 700, 1'b0);
    run_frame(0, 1'b1, 1, 700, 1'b0);

    // Frame start landing on the active-to-blank edge must clear the line count.
    run_frame(2, 1'b0, 18, 64, 1'b0);
    run_line(64, 6, 1'b1, -1);
    run_line(64, 6, 1'b0, -1);

    run_frame(1, 1'b0, 0, 0, 1'b0);
    run_line(640, 6, 1'b0, 300);
    run_frame(2, 1'b1, 2, 640, 1'b0);

    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 700)),
                1'($urandom_range(0, 1)));
    end

    repeat (3) apply_stimulus(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter H_RES, default 640: active pixels per line.
REQ-002 Parameter V_RES, default 480: active lines per frame.
REQ-003 Parameter PIX_SZ, default 8: bits per colour channel, 1..16.
REQ-004 Parameter NUM_BARS, default 8: colour bar count, power of two, 2..8, H_RES divisible by NUM_BARS.
REQ-005 Parameter CHK_LOG2, default 4: checkerboard square side = 2^CHK_LOG2 pixels.
REQ-006 i_clk  input  1  pixel clock; all logic on rising edge.
REQ-007 i_rst  input  1  reset; asynchronous, active-low.
REQ-008 i_blank  input  1  high outside the active video area.
REQ-009 i_frame_start  input  1  one-cycle pulse, asserted while i_blank=1, before line 0 of each frame.
REQ-010 i_mode  input  2  pattern select: 0 bars, 1 gradient, 2 checkerboard, 3 solid.
REQ-011 i_scroll_en  input  1  enables per-frame horizontal scroll of the bar pattern.
REQ-012 i_solid_rgb  input  3*PIX_SZ  solid colour {r,g,b}, used in mode 3.
REQ-013 o_r, o_g, o_b  output  PIX_SZ each  registered pixel channels.
REQ-014 o_de  output  1  registered data enable, equal to ~i_blank delayed one cycle.

Function
REQ-015 Latency: o_r/o_g/o_b/o_de SHALL reflect the i_blank/x/y of the previous clock cycle, i.e. exactly 1 cycle.
REQ-016 Pixel counter x (clog2(H_RES) bits): +1 on each cycle with i_blank=0; cleared on the first cycle with i_blank=1 after an active cycle.
REQ-017 Line counter y (clog2(V_RES) bits): +1 on each active-to-blank transition; cleared on i_frame_start; saturates at V_RES-1.
REQ-018 Frame state: on i_frame_start, i_mode SHALL be latched into mode_q, and scroll offset s SHALL become (s+1) mod H_RES if i_scroll_en=1, else 0; i_mode changes mid-frame SHALL have no effect until the next i_frame_start.
REQ-019 Simultaneous i_frame_start and active-to-blank transition: y SHALL clear (clear wins).
REQ-020 Mode 0: xs=(x+s) mod H_RES; bar_id=xs/(H_RES/NUM_BARS), 3 bits, zero-extended when NUM_BARS<8; r=all ~bar_id[1], g=all ~bar_id[2], b=all ~bar_id[0] (bar 0 white ... bar 7 black).
REQ-021 Mode 1: r=g=b=x[PIX_SZ-1:0], zero-extended if x is narrower; wraps every 2^PIX_SZ pixels.
REQ-022 Mode 2: c=x[CHK_LOG2]^y[CHK_LOG2]; all channels all-ones when c=0, zero when c=1 (pixel (0,0) white).
REQ-023 Mode 3: {r,g,b}=i_solid_rgb as sampled on the active cycle (not latched per frame).
REQ-024 Any cycle with i_blank=1: next o_r/o_g/o_b SHALL be zero and o_de 0, regardless of mode.
REQ-025 Counters SHALL not exceed range: x beyond H_RES-1 (overlong active period) holds at H_RES-1.

Reset
REQ-026 While i_rst=0: x, y, s, mode_q, o_r, o_g, o_b, o_de SHALL all be 0, asynchronously.
REQ-027 After release, mode_q remains 0 (bars) until the first i_frame_start.
REQ-028 Reset asserted mid-line SHALL take effect immediately; first frame after release starts at next i_frame_start.

Verification
REQ-029 Defaults, mode 0, no scroll, one line of 640 active cycles -> 8 bars of 80 pixels: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, each appearing 1 cycle after the corresponding x.
REQ-030 Mode 0, i_scroll_en=1, three frames -> on frame 3 (s=3) first white run is 77 pixels and bar boundaries shift left by 3.
REQ-031 Mode 2, lines 0 and 16 -> line 0 pixel 0..15 white, 16..31 black; line 16 inverted.
REQ-032 Mode 1, PIX_SZ=8 -> pixel 255 outputs 0xFF on all channels, pixel 256 outputs 0x00.
REQ-033 Change i_mode 0->3 mid-line with i_solid_rgb=0x123456 -> output stays bars until next i_frame_start, then 0x123456 for all active pixels; blank cycles 0 with o_de=0.
REQ-034 Assert i_rst=0 at pixel 300 -> outputs 0 same cycle without a clock edge; after release and i_frame_start, line 0 starts at x=0 in mode as latched.
